// File: rtl/counter_seq_ctrl.sv
// Start/limit/mode sequencer for the N-bit counter datapath: counts 0..limit on tick,
// with pause, abort, one-shot and auto-reload operation.
//
//   state | meaning
//   IDLE  | waiting for start_i; count holds its last value
//   RUN   | counting on tick_i toward limit_q
//   PAUSE | frozen while pause_i is high; tick_i ignored
//   DONE  | one-cycle terminal pulse for one-shot runs
module counter_seq_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         pause_i,
  input  logic         tick_i,
  input  logic         mode_i,
  input  logic [N-1:0] limit_i,
  output logic [N-1:0] count_o,
  output logic         busy_o,
  output logic         paused_o,
  output logic         done_o,
  output logic         wrap_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] limit_q;
  logic         mode_q;
  logic         wrap_q, wrap_d;
  logic         capture;
  logic         at_limit;

  assign capture  = (state_q == IDLE) && start_i;
  assign at_limit = (count_q == limit_q);

  // abort beats pause beats tick while running
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (pause_i) begin
          state_d = PAUSE;
        end else if (tick_i) begin
          if (!at_limit) begin
            count_d = count_q + ONE;
          end else if (mode_q) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (!pause_i) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      if (capture) begin
        limit_q <= limit_i;
        mode_q  <= mode_i;
      end
    end
  end

  assign count_o  = count_q;
  assign busy_o   = (state_q == RUN) || (state_q == PAUSE);
  assign paused_o = (state_q == PAUSE);
  assign done_o   = (state_q == DONE);
  assign wrap_o   = wrap_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl (N=3): reset, one-shot, auto-reload, pause,
// abort priority and limit boundaries, with hand-computed expectations.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i, abort_i, pause_i, tick_i, mode_i;
  logic [2:0] limit_i;
  logic [2:0] count_o;
  logic       busy_o, paused_o, done_o, wrap_o;

  int total = 0;
  int passed = 0;

  counter_seq_ctrl #(.N(3)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
    .pause_i(pause_i), .tick_i(tick_i), .mode_i(mode_i), .limit_i(limit_i),
    .count_o(count_o), .busy_o(busy_o), .paused_o(paused_o),
    .done_o(done_o), .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input int cnt, input int busy,
                        input int pau, input int dn, input int wr);
    chk({tag, ".count"},  int'(count_o),  cnt);
    chk({tag, ".busy"},   int'(busy_o),   busy);
    chk({tag, ".paused"}, int'(paused_o), pau);
    chk({tag, ".done"},   int'(done_o),   dn);
    chk({tag, ".wrap"},   int'(wrap_o),   wr);
  endtask

  task automatic start_run(input int lim, input logic md);
    start_i = 1'b1;
    limit_i = 3'(lim);
    mode_i  = md;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start_i = 0; abort_i = 0; pause_i = 0; tick_i = 0;
    mode_i = 0; limit_i = '0;
    step(); step();
    chk_st("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    chk_st("idle", 0, 0, 0, 0, 0);

    // one-shot, limit 5; limit/mode changes and start pulses mid-run are ignored
    tick_i = 1'b1;
    start_run(5, 1'b0);
    limit_i = 3'd2; mode_i = 1'b1;
    chk_st("os.t1", 0, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      start_i = (k == 3);
      step();
      chk_st("os.step", k, 1, 0, 0, 0);
    end
    start_i = 1'b1;
    step();
    chk_st("os.done", 5, 0, 0, 1, 0);
    step();
    chk_st("os.start_in_done", 5, 0, 0, 0, 0);
    start_i = 1'b0;
    step();
    chk_st("os.idle_hold", 5, 0, 0, 0, 0);

    // synchronous reset mid-run
    start_run(5, 1'b0);
    step(); step();
    chk("rst.pre", int'(count_o), 2);
    reset = 1'b0;
    step();
    chk_st("rst.mid", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // auto-reload, limit 2: 1,2,0w,1,2,0w,1 then abort
    start_run(2, 1'b1);
    chk_st("ar.t1", 0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_st("ar.seq", i % 3, 1, 0, 0, (i % 3 == 0) ? 1 : 0);
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk_st("ar.abort", 1, 0, 0, 0, 0);
    step();
    chk_st("ar.after", 1, 0, 0, 0, 0);

    // pause at count 3 for 4 cycles with tick high, then run to limit 7
    start_run(7, 1'b0);
    step(); step(); step();
    chk("pz.pre", int'(count_o), 3);
    pause_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_st("pz.hold", 3, 1, 1, 0, 0);
    end
    pause_i = 1'b0;
    step();
    chk_st("pz.resume", 3, 1, 0, 0, 0);
    for (int k = 4; k <= 7; k++) begin
      step();
      chk_st("pz.count", k, 1, 0, 0, 0);
    end
    step();
    chk_st("lim7.done", 7, 0, 0, 1, 0);
    step();

    // abort and pause together in RUN -> IDLE
    start_run(7, 1'b0);
    step();
    abort_i = 1'b1; pause_i = 1'b1;
    step();
    abort_i = 1'b0; pause_i = 1'b0;
    chk_st("prio", 1, 0, 0, 0, 0);

    // abort from PAUSE
    start_run(7, 1'b0);
    pause_i = 1'b1;
    step();
    chk_st("pab.pause", 0, 1, 1, 0, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0; pause_i = 1'b0;
    chk_st("pab.abort", 0, 0, 0, 0, 0);

    // tick low holds count in RUN
    tick_i = 1'b0;
    start_run(3, 1'b0);
    step(); step();
    chk_st("tk.hold0", 0, 1, 0, 0, 0);
    tick_i = 1'b1;
    step();
    chk("tk.one", int'(count_o), 1);
    tick_i = 1'b0;
    step(); step();
    chk_st("tk.hold1", 1, 1, 0, 0, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;

    // limit 0: done two cycles after start
    tick_i = 1'b1;
    start_run(0, 1'b0);
    chk_st("l0.t1", 0, 1, 0, 0, 0);
    step();
    chk_st("l0.done", 0, 0, 0, 1, 0);
    step();
    chk_st("l0.idle", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
